mem_read_ctrl: RTL and testbench

Read-burst sequencer that drives the single rd_en/rd_addr input of the skewed multi-bank BRAM read fan-out. On a start pulse it issues a tiled read pattern: num_tiles tiles of num_rows consecutive addresses, with tile bases separated by tile_stride. After the last issue it drains for the bank skew plus the BRAM read latency, then signals done. It sits between the layer/op controller and the bank-skew stage feeding the systolic array.

---
 rtl/mem_read_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mem_read_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_read_ctrl.sv
// mem_read_ctrl: tiled read-burst sequencer driving the rd_en/rd_addr input
// of the skewed multi-bank BRAM read fan-out.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : burst request, sampled only while idle
//   base_addr, num_rows, num_tiles, tile_stride : burst config, captured at start
//   stall           : backpressure, suppresses the read issued on the next cycle
//   rd_en, rd_addr  : registered read request to the skew stage
//   rd_last         : marks the final read of each tile
//   busy            : high from the cycle after start through the done cycle
//   done            : one-cycle pulse once the last bank's data has left the BRAM
module mem_read_ctrl #(
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned LEN_W  = 12,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_rows,
    input  logic [LEN_W-1:0]  num_tiles,
    input  logic [ADDR_W-1:0] tile_stride,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last,
    output logic              busy,
    output logic              done
);

    // Drain covers the skew chain (N-1) plus the BRAM read latency.
    localparam int unsigned DRAIN_LEN = N - 1 + RD_LAT;
    localparam int unsigned DCNT_W    = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    rows_q, rows_d;
    logic [LEN_W-1:0]    tiles_q, tiles_d;
    logic [ADDR_W-1:0]   stride_q, stride_d;
    logic [ADDR_W-1:0]   tile_base_q, tile_base_d;
    logic [LEN_W-1:0]    r_q, r_d;
    logic [LEN_W-1:0]    t_q, t_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_last_q, rd_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                last_row_c;
    logic                last_tile_c;
    logic [LEN_W-1:0]    r_inc_c;

    // r_q/t_q always index the most recently issued read.
    assign last_row_c  = (r_q == rows_q - LEN_W'(1));
    assign last_tile_c = (t_q == tiles_q - LEN_W'(1));
    assign r_inc_c     = r_q + LEN_W'(1);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rows_q      <= '0;
            tiles_q     <= '0;
            stride_q    <= '0;
            tile_base_q <= '0;
            r_q         <= '0;
            t_q         <= '0;
            dcnt_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rows_q      <= rows_d;
            tiles_q     <= tiles_d;
            stride_q    <= stride_d;
            tile_base_q <= tile_base_d;
            r_q         <= r_d;
            t_q         <= t_d;
            dcnt_q      <= dcnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            rd_last_q   <= rd_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        rows_d      = rows_q;
        tiles_d     = tiles_q;
        stride_d    = stride_q;
        tile_base_d = tile_base_q;
        r_d         = r_q;
        t_d         = t_q;
        dcnt_d      = dcnt_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        rd_last_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rows_d      = num_rows;
                    tiles_d     = num_tiles;
                    stride_d    = tile_stride;
                    tile_base_d = base_addr;
                    r_d         = '0;
                    t_d         = '0;
                    busy_d      = 1'b1;
                    if ((num_rows == '0) || (num_tiles == '0)) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_ISSUE;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_addr;
                        rd_last_d = (num_rows == LEN_W'(1));
                    end
                end
            end

            S_ISSUE: begin
                // The final read is already out, so a stall here cannot cancel it.
                if (last_row_c && last_tile_c) begin
                    state_d = S_DRAIN;
                    dcnt_d  = '0;
                end else if (!stall) begin
                    rd_en_d = 1'b1;
                    if (last_row_c) begin
                        r_d         = '0;
                        t_d         = t_q + LEN_W'(1);
                        tile_base_d = tile_base_q + stride_q;
                        rd_addr_d   = tile_base_q + stride_q;
                        rd_last_d   = (rows_q == LEN_W'(1));
                    end else begin
                        r_d       = r_inc_c;
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        rd_last_d = (r_inc_c == rows_q - LEN_W'(1));
                    end
                end
            end

            S_DRAIN: begin
                if (dcnt_q == DCNT_W'(DRAIN_LEN - 1)) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign rd_last = rd_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Scoreboard bench for mem_read_ctrl: expected reads/done events are queued at
// start time and checked by an independent monitor on the falling edge.
module tb_mem_read_ctrl;

    logic        clk;
    logic        rst_n;
    logic        m_start;
    logic        x_start;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] num_rows;
    logic [11:0] num_tiles;
    logic [11:0] tile_stride;
    logic        stall;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic        rd_last;
    logic        busy;
    logic        done;

    typedef struct {
        bit          is_done;
        int          cyc;
        logic [11:0] addr;
        logic        last;
    } ev_t;

    ev_t sb[$];
    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_bad  = 0;
    int  st_lo  = -10;
    int  st_hi  = -20;
    int  xs_a   = -1;
    int  xs_b   = -1;

    assign start = m_start | x_start;

    mem_read_ctrl #(.N(4), .ADDR_W(12), .LEN_W(12), .RD_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .num_tiles  (num_tiles),
        .tile_stride(tile_stride),
        .stall      (stall),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_last    (rd_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stall window and extra (should-be-ignored) start pulses, by absolute cycle.
    always @(posedge clk) begin
        #1;
        stall   = (cyc >= st_lo) && (cyc <= st_hi);
        x_start = (cyc == xs_a) || (cyc == xs_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic pr(input int t0, input int c, input logic [11:0] a, input logic l);
        ev_t e;
        e.is_done = 1'b0; e.cyc = t0 + c; e.addr = a; e.last = l;
        sb.push_back(e);
    endtask

    task automatic pd(input int t0, input int c);
        ev_t e;
        e.is_done = 1'b1; e.cyc = t0 + c; e.addr = '0; e.last = 1'b0;
        sb.push_back(e);
    endtask

    // Monitor: every rd_en or done must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event at cycle %0d: got none expected %s at cycle %0d",
                         cyc, sb[0].is_done ? "done" : "read", sb[0].cyc);
                void'(sb.pop_front());
            end
            if (rd_en) begin
                if (sb.size() == 0) begin
                    chk("unexpected_read", 32'(rd_addr), 32'hFFFF_FFFF);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("read_kind", 32'(e.is_done), 32'd0);
                    chk("read_cycle", 32'(cyc), 32'(e.cyc));
                    chk("rd_addr", 32'(rd_addr), 32'(e.addr));
                    chk("rd_last", 32'(rd_last), 32'(e.last));
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("done_kind", 32'(e.is_done), 32'd1);
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (!rd_en && rd_last)
                chk("rd_last_without_rd_en", 32'(rd_last), 32'd0);
        end
    end

    // Called just after a rising edge; the start pulse is sampled at the next edge.
    task automatic issue(input logic [11:0] b, input logic [11:0] rows, input logic [11:0] tiles,
                         input logic [11:0] str, output int t0);
        t0          = cyc;
        base_addr   = b;
        num_rows    = rows;
        num_tiles   = tiles;
        tile_stride = str;
        m_start     = 1'b1;
        @(posedge clk);
        #1;
        m_start     = 1'b0;
        // Config changes after the start cycle must have no effect.
        base_addr   = 12'hABC;
        num_rows    = 12'd7;
        num_tiles   = 12'd9;
        tile_stride = 12'h111;
    endtask

    // Walk cycles t0+1..t0+upto checking busy, then require an empty scoreboard.
    task automatic check_busy(input int t0, input int hi, input int upto);
        for (int c = 1; c <= upto; c++) begin
            @(negedge clk);
            chk($sformatf("busy_c%0d", c), 32'(busy), 32'(c <= hi));
        end
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic push_basic(input int t0);
        pr(t0, 1, 12'h010, 1'b0);
        pr(t0, 2, 12'h011, 1'b0);
        pr(t0, 3, 12'h012, 1'b1);
        pr(t0, 4, 12'h030, 1'b0);
        pr(t0, 5, 12'h031, 1'b0);
        pr(t0, 6, 12'h032, 1'b1);
        pd(t0, 12);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0; m_start = 1'b0; x_start = 1'b0; stall = 1'b0;
        base_addr = '0; num_rows = '0; num_tiles = '0; tile_stride = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);
        chk("reset_rd_last", 32'(rd_last), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst with ignored starts at cycles 4 and 12, then a start at 13.
        xs_a = cyc + 4;
        xs_b = cyc + 12;
        issue(12'h010, 12'd3, 12'd2, 12'h020, t0);
        push_basic(t0);
        check_busy(t0, 12, 12);
        xs_a = -1;
        xs_b = -1;
        @(posedge clk);
        #1;
        chk("restart_cycle", 32'(cyc - t0), 32'd13);
        issue(12'h010, 12'd3, 12'd2, 12'h020, t0);
        push_basic(t0);
        check_busy(t0, 12, 13);

        // Stall in cycles 2-3.
        @(posedge clk);
        #1;
        st_lo = cyc + 2;
        st_hi = cyc + 3;
        issue(12'h010, 12'd3, 12'd2, 12'h020, t0);
        pr(t0, 1, 12'h010, 1'b0);
        pr(t0, 2, 12'h011, 1'b0);
        pr(t0, 5, 12'h012, 1'b1);
        pr(t0, 6, 12'h030, 1'b0);
        pr(t0, 7, 12'h031, 1'b0);
        pr(t0, 8, 12'h032, 1'b1);
        pd(t0, 14);
        check_busy(t0, 14, 15);

        // Stall during the final read's cycle: timing unchanged.
        @(posedge clk);
        #1;
        st_lo = cyc + 6;
        st_hi = cyc + 6;
        issue(12'h010, 12'd3, 12'd2, 12'h020, t0);
        push_basic(t0);
        check_busy(t0, 12, 13);
        st_lo = -10;
        st_hi = -20;

        // Zero rows, then zero tiles.
        @(posedge clk);
        #1;
        issue(12'h010, 12'd0, 12'd5, 12'h020, t0);
        pd(t0, 1);
        check_busy(t0, 1, 3);
        @(posedge clk);
        #1;
        issue(12'h010, 12'd3, 12'd0, 12'h020, t0);
        pd(t0, 1);
        check_busy(t0, 1, 3);

        // Address wrap.
        @(posedge clk);
        #1;
        issue(12'hFFE, 12'd4, 12'd1, 12'h000, t0);
        pr(t0, 1, 12'hFFE, 1'b0);
        pr(t0, 2, 12'hFFF, 1'b0);
        pr(t0, 3, 12'h000, 1'b0);
        pr(t0, 4, 12'h001, 1'b1);
        pd(t0, 10);
        check_busy(t0, 10, 11);

        // Asynchronous reset in cycle 4 of a basic burst.
        @(posedge clk);
        #1;
        issue(12'h010, 12'd3, 12'd2, 12'h020, t0);
        push_basic(t0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_rd_en", 32'(rd_en), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        chk("async_rst_rd_addr", 32'(rd_addr), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        issue(12'h010, 12'd3, 12'd2, 12'h020, t0);
        push_basic(t0);
        check_busy(t0, 12, 13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
